// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and a debug/loader master (port 1).
// Tie policy: fixed priority to port 0 by default; round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   tie_to_1;

`ifdef DMEM_ARB_RR_EN
  // Round-robin: on a tie the port that was not granted most recently wins.
  assign tie_to_1 = ~last;
`else
  // Fixed priority: port 0 always wins; last is still tracked for observability.
  assign tie_to_1 = last & 1'b0;
`endif

  always_comb begin
    state_nxt = IDLE;
    if (req0 && req1) begin
      state_nxt = tie_to_1 ? GNT1 : GNT0;
    end else if (req0) begin
      state_nxt = GNT0;
    end else if (req1) begin
      state_nxt = GNT1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == GNT0);
      gnt1  <= (state_nxt == GNT1);
      if (state_nxt == GNT0) begin
        last <= 1'b0;
      end else if (state_nxt == GNT1) begin
        last <= 1'b1;
      end
    end
  end

  // A request dropped during its own grant cycle produces no memory strobe.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      GNT0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_we    = req0 & we0;
        mem_re    = req0 & ~we0;
      end
      GNT1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_we    = req1 & we1;
        mem_re    = req1 & ~we1;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= (state == GNT0) && mem_re;
      rvalid1 <= (state == GNT1) && mem_re;
      if ((state == GNT0) && mem_re) begin
        rdata0 <= mem_rdata;
      end
      if ((state == GNT1) && mem_re) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 128×16 data memory between the CPU load/store path (port 0) and a debug/loader master (port 1). It sits between the CPU datapath (ALU result as address, rt as write data) and the data memory's `data`/`addr`/`we`/`re`/`strm` pins. It serialises accesses with a registered grant and returns read data one cycle after the granted access. Port 0 sees a low `gnt0` while its `req0` is pending as a stall.

## Interface
Parameters:
- `ADDR_W`, 7, word-address width (128 words).
- `DATA_W`, 16, data word width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0` / `req1`  in  1  access request, per port.
- `we0` / `we1`  in  1  1 = write, 0 = read. Held stable while `reqN` is high.
- `addr0` / `addr1`  in  ADDR_W  word address. Held stable while `reqN` is high.
- `wdata0` / `wdata1`  in  DATA_W  write data. Held stable while `reqN` is high.
- `gnt0` / `gnt1`  out  1  registered grant; the access is performed in the cycle `gntN` is high.
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data-valid pulse.
- `rdata0` / `rdata1`  out  DATA_W  registered read data. Held until the next read completes on that port.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_wdata`  out  DATA_W  to memory `data`.
- `mem_we`  out  1  to memory `we`.
- `mem_re`  out  1  to memory `re`.
- `mem_rdata`  in  DATA_W  from memory `strm`; combinational read.

## Operation
- FSM states: IDLE, GNT0, GNT1. The state register drives `gnt0 = (state==GNT0)` and `gnt1 = (state==GNT1)`. The two grants are never both 1.
- Arbitration is evaluated every cycle from the live `req0`/`req1`. The next state is GNT0, GNT1 or IDLE (no request).
- Only one port requesting: that port wins.
- Both ports requesting: the winner is chosen by the policy in Configuration.
- Back-to-back grants are allowed. From GNTx the FSM may go directly to either grant state.
- The `last` pointer is 1 bit and records the most recently granted port. It updates on entry to GNT0/GNT1.
- Memory mux in GNTn: `mem_addr = addrN`, `mem_wdata = wdataN`, `mem_we = reqN & weN`, `mem_re = reqN & ~weN`.
- Memory mux outside grant states: all memory outputs are 0.
- Write: commits at the rising edge that ends the GNTn cycle.
- Read: `mem_rdata` is captured into `rdataN` at that same edge, and `rvalidN` is 1 for the following cycle.
- Withdrawn request: if `reqN` drops during its GNTn cycle, no memory access occurs and `rvalidN` stays 0. The grant cycle is consumed.
- A requester treats `reqN & gntN` at a rising edge as completion. Keeping `reqN` high afterwards issues a new request.
- Reset values:
  - state = IDLE, so `gnt0 = gnt1 = 0`;
  - `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0`;
  - `last = 1`, so port 0 wins the first tie;
  - all `mem_*` outputs = 0.
- Reset mid-operation: asserting `rst` during GNTn aborts the access. No write is committed, no `rvalid` pulse is produced, and the FSM returns to IDLE.

## Timing
- Read latency from request to data:
  - `req` seen at edge k;
  - `gnt` high in cycle k+1;
  - `rvalid`/`rdata` valid in cycle k+2.
- Write completes at the end of the `gnt` cycle (edge k+2).
- Sustained throughput is 1 access/cycle. A single continuously requesting port is granted every cycle after the first.
- Under round-robin with both ports requesting continuously, grants alternate and each port gets 1 access per 2 cycles. Maximum wait is 1 extra cycle.
- The CPU must stall its PC while `req0 & ~gnt0`. A load result is usable only on `rvalid0`.

## Configuration
- `DMEM_ARB_RR_EN` defined: on a tie, grant the port ≠ `last` (round-robin).
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 (CPU) always wins ties. Port 1 may starve. The `last` register is still present but unused for the decision.

## Test plan
- Reset release, no requests: `gnt0/1`, `rvalid0/1`, `rdata0/1` and all `mem_*` stay 0 for 10 cycles.
- Port 0 single write then read:
  - `req0 we0=1 addr0=5 wdata0=0x00AB` → `gnt0` high one cycle, `mem_we=1`, `mem_addr=5`;
  - then `req0 we0=0 addr0=5` → `gnt0` next cycle, then `rvalid0=1`, `rdata0=0x00AB`.
- Simultaneous reads `req0 addr0=1`, `req1 addr1=2`, memory preloaded 0x0023/0x0009:
  - RR build: `gnt0` then `gnt1`; `rdata0=0x0023`, then `rdata1=0x0009` one cycle later.
- Both ports held continuously for 8 cycles:
  - RR build: grants alternate 0,1,0,1…;
  - fixed-priority build: `gnt0` every cycle, `gnt1` never.
- Withdrawn request: `req1` drops in its GNT1 cycle → `mem_re=0`, `mem_we=0`, no `rvalid1`; `rdata1` keeps its previous value.
- Reset mid-write: assert `rst` low during GNT0 with `we0=1 addr0=9 wdata0=0xFFFF` → memory word 9 unchanged by the write, FSM returns to IDLE, `rvalid0=0`.
